// File: rtl/robotron_sound_sched.sv
// Fixed-priority sound command scheduler driving robotron_sound PB_IN/HAND_IN (active-low, 6'h3F idle).
// Optional HOLD preemption by a higher-priority requester: define ROBOTRON_SND_PREEMPT_EN.
module robotron_sound_sched #(
  parameter  int NREQ        = 4,
  parameter  int HOLD_CYCLES = 64,
  parameter  int GAP_CYCLES  = 32,
  localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] code,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [IDW-1:0]    cur_id,
  output logic [5:0]        pb_out,
  output logic              hand_out
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [5:0] PB_IDLE = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]        r_ack, w_ack_nxt;
  logic [IDW-1:0]         r_cur, w_cur_nxt;
  logic [5:0]             r_pb, w_pb_nxt;
  logic                   r_hand, w_hand_nxt;

  logic [NREQ-1:0][5:0]   w_code;
  logic                   w_any;
  logic [IDW-1:0]         w_gid;
  logic [5:0]             w_gcode;
  logic                   w_preempt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_code[gi] = code[6*gi +: 6];
  end

`ifdef ROBOTRON_SND_PREEMPT_EN
  // Any pending request strictly above the current holder's priority.
  logic [NREQ-1:0] w_hi;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hi
    assign w_hi[gi] = req[gi] && (IDW'(gi) < r_cur);
  end
  assign w_preempt = |w_hi;
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_gid = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) w_gid = IDW'(i);
    end
  end

  assign w_any   = |req;
  assign w_gcode = w_code[w_gid];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_ack_nxt   = '0;
    w_cur_nxt   = r_cur;
    w_pb_nxt    = r_pb;
    w_hand_nxt  = r_hand;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_any) begin
          w_ack_nxt = NREQ'(1) << w_gid;
          w_cur_nxt = w_gid;
          // A zero code would look like idle on the bus, so it is acked without holding.
          if (w_gcode != 6'h00) begin
            w_state_nxt = S_HOLD;
            w_pb_nxt    = ~w_gcode;
            w_hand_nxt  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (w_preempt || r_cnt == CW'(HOLD_CYCLES-1)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
          w_pb_nxt    = PB_IDLE;
          w_hand_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP_CYCLES-1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pb_nxt    = PB_IDLE;
        w_hand_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_cur   <= '0;
      r_pb    <= PB_IDLE;
      r_hand  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_cur   <= w_cur_nxt;
      r_pb    <= w_pb_nxt;
      r_hand  <= w_hand_nxt;
    end
  end

  assign ack      = r_ack;
  assign busy     = (r_state != S_IDLE);
  assign cur_id   = r_cur;
  assign pb_out   = r_pb;
  assign hand_out = r_hand;

endmodule

// File: tb/tb_robotron_sound_sched.sv
// Bench for robotron_sound_sched: directed vector table, corner sequences, random traffic vs a timer model.
module tb_robotron_sound_sched;
  localparam int NREQ = 4;
  localparam int H    = 4;
  localparam int G    = 2;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] code;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  cur_id;
  logic [5:0]  pb_out;
  logic        hand_out;

  robotron_sound_sched #(.NREQ(NREQ), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .req(req), .code(code),
    .ack(ack), .busy(busy), .cur_id(cur_id), .pb_out(pb_out), .hand_out(hand_out)
  );

  always #5 clk_cpu = ~clk_cpu;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining hold / gap time, counted down once per clock.
  int         m_hold = 0;
  int         m_gap  = 0;
  logic [3:0] m_ack  = '0;
  logic [1:0] m_cur  = '0;
  logic [5:0] m_code = '0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [23:0] code;
    logic [13:0] exp;
  } vec_t;

  function automatic logic [13:0] mk(input logic [3:0] a, input logic b, input logic [1:0] c,
                                     input logic [5:0] p, input logic h);
    return {a, b, c, p, h};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [3:0] rq, input logic [23:0] cd,
                               input logic [3:0] a, input logic b, input logic [1:0] c,
                               input logic [5:0] p, input logic h);
    vec_t v;
    v.rst = r; v.req = rq; v.code = cd; v.exp = mk(a, b, c, p, h);
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {ack, busy, cur_id, pb_out, hand_out};
  endfunction

  function automatic logic [13:0] model_vec();
    return mk(m_ack, (m_hold > 0) || (m_gap > 0), m_cur,
              (m_hold > 0) ? ~m_code : 6'h3F, m_hold == 0);
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] rq, input logic [23:0] cd);
    int g;
    bit pre;
    pre = 1'b0;
    m_ack = '0;
    if (rst) begin
      m_hold = 0; m_gap = 0; m_cur = '0;
    end else if (m_hold > 0) begin
`ifdef ROBOTRON_SND_PREEMPT_EN
      for (int i = 0; i < int'(m_cur); i++) if (rq[i]) pre = 1'b1;
`endif
      if (pre || m_hold == 1) begin m_hold = 0; m_gap = G; end
      else m_hold--;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (rq != 4'b0) begin
      g = 0;
      for (int i = NREQ-1; i >= 0; i--) if (rq[i]) g = i;
      m_ack  = 4'b0001 << g;
      m_cur  = 2'(g);
      m_code = cd[6*g +: 6];
      if (m_code != 6'h00) m_hold = H;
    end
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (ack,busy,cur,pb,hand) t=%0t", name, got, want, $time);
    end
  endtask

  // One clock: sample inputs at the edge, step the model, compare #1 later.
  task automatic cyc(input string name);
    logic        r;
    logic [3:0]  rq;
    logic [23:0] cd;
    r = reset; rq = req; cd = code;
    @(posedge clk_cpu);
    #1;
    model_step(r, rq, cd);
    check(name, dut_vec(), model_vec());
  endtask

  task automatic drain();
    req = '0;
    for (int k = 0; k < 20 && (m_hold > 0 || m_gap > 0); k++) cyc("drain");
  endtask

  vec_t tbl[$];

  initial begin
    logic [23:0] c1, c2;
    logic        h3;
    int          got_cyc;
    int          exp_cyc;

    reset = 1'b1; req = '0; code = '0;
    c1 = {6'h00, 6'h05, 6'h00, 6'h00};
    c2 = {6'h22, 6'h00, 6'h11, 6'h00};

    for (int k = 0; k < 3; k++) tbl.push_back(mkv(1, 4'hF, '0, 4'h0, 0, 0, 6'h3F, 1));
    tbl.push_back(mkv(0, 4'h4, c1, 4'h4, 1, 2, 6'h3A, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mkv(0, 4'h0, c1, 4'h0, 1, 2, 6'h3A, 0));
    for (int k = 0; k < 2; k++) tbl.push_back(mkv(0, 4'h0, c1, 4'h0, 1, 2, 6'h3F, 1));
    tbl.push_back(mkv(0, 4'h0, c1, 4'h0, 0, 2, 6'h3F, 1));
    tbl.push_back(mkv(0, 4'hA, c2, 4'h2, 1, 1, 6'h2E, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mkv(0, 4'h8, c2, 4'h0, 1, 1, 6'h2E, 0));
    for (int k = 0; k < 2; k++) tbl.push_back(mkv(0, 4'h8, c2, 4'h0, 1, 1, 6'h3F, 1));
    tbl.push_back(mkv(0, 4'h8, c2, 4'h0, 0, 1, 6'h3F, 1));
    tbl.push_back(mkv(0, 4'h8, c2, 4'h8, 1, 3, 6'h1D, 0));
    tbl.push_back(mkv(0, 4'h0, c2, 4'h0, 1, 3, 6'h1D, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; req = tbl[k].req; code = tbl[k].code;
      @(posedge clk_cpu);
      #1;
      model_step(tbl[k].rst, tbl[k].req, tbl[k].code);
      check($sformatf("vec%0d", k), dut_vec(), tbl[k].exp);
    end
    drain();

    // Null command, then immediate grant of the next requester.
    req = 4'b0001; code = '0;
    cyc("null_model");
    check("null_out", dut_vec(), mk(4'h1, 0, 0, 6'h3F, 1));
    req = 4'b0010; code = {6'h00, 6'h00, 6'h15, 6'h00};
    cyc("after_null_model");
    check("after_null_out", dut_vec(), mk(4'h2, 1, 1, 6'h2A, 0));
    drain();

    // Reset in the middle of HOLD.
    req = 4'b0100; code = {6'h00, 6'h07, 6'h00, 6'h00};
    cyc("rh_grant");
    req = '0;
    cyc("rh_t2");
    reset = 1'b1;
    cyc("rh_rst_model");
    check("rst_hold", dut_vec(), mk(4'h0, 0, 0, 6'h3F, 1));
    reset = 1'b0;

    // Reset in the middle of GAP.
    req = 4'b0100;
    cyc("rg_grant");
    req = '0;
    for (int k = 0; k < H; k++) cyc("rg_run");
    check("rg_in_gap", dut_vec(), mk(4'h0, 1, 2, 6'h3F, 1));
    reset = 1'b1;
    cyc("rg_rst_model");
    check("rst_gap", dut_vec(), mk(4'h0, 0, 0, 6'h3F, 1));
    reset = 1'b0;

    // Higher-priority request arriving during HOLD of requester 3.
    req = 4'b1000; code = {6'h09, 6'h00, 6'h00, 6'h03};
    cyc("pe_grant");
    req = '0;
    cyc("pe_t2");
    req = 4'b0001;
    got_cyc = -1; h3 = 1'bx;
    for (int n = 1; n <= 12; n++) begin
      cyc("pe_run");
      if (n == 1) h3 = hand_out;
      if (ack[0]) begin got_cyc = n + 2; break; end
    end
    req = '0;
`ifdef ROBOTRON_SND_PREEMPT_EN
    exp_cyc = 6;
    check("preempt_t3_hand", {13'b0, h3}, 14'd1);
`else
    exp_cyc = 8;
    check("preempt_t3_hand", {13'b0, h3}, 14'd0);
`endif
    total++;
    if (got_cyc != exp_cyc) begin
      bad++;
      $display("FAIL preempt_grant got=t+%0d want=t+%0d", got_cyc, exp_cyc);
    end
    drain();

    // Random traffic under the ack handshake protocol.
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          code[6*i +: 6] = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
          req[i] = 1'b1;
        end else if (!req[i]) begin
          code[6*i +: 6] = 6'($urandom);
        end
      end
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
